unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
- Multi-cycle control unit directly upstream of the RV64 datapath.
- Consumes the datapath's `instru` output, latches it into an instruction register, and decodes it.
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath control input plus `imm_ext`.
- Adds `pc_en`, which gates the program counter so each instruction advances the PC exactly once.

Parameters:
- BITS, 63, MSB index of datapath words; words are BITS+1 bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- instru  input  32  instruction word from instruction memory at the current PC.
- pc_en  output  1  one-cycle PC update enable, asserted in the last state of each instruction.
- load_en  output  1  register-file write enable.
- store_en  output  1  data-RAM write enable.
- op_ula  output  4  ALU operation.
- operation_type  output  2  writeback source: 00 ula_out, 01 mem_read, 10 pc.
- ula_entry  output  1  ALU B source: 0 imm_ext, 1 rs2.
- branch, auipc, jal, jalr  output  1 each  PC-update mode flags.
- sign  output  1  signed compare when 1.
- imm_ext  output  BITS+1  sign-extended immediate.
- illegal  output  1  sticky unsupported-opcode flag.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values:
  - state = FETCH; IR = 32'h00000013 (nop).
  - pc_en, load_en, store_en, branch, auipc, jal, jalr, illegal = 0.
  - op_ula = 0000; operation_type = 00; ula_entry = 0; sign = 1; imm_ext = 0.
- Reset mid-instruction aborts it: no write enable and no pc_en is issued in that cycle or the next.
- State transitions:
  - FETCH: IR <= instru; next DECODE.
  - DECODE: decode from IR; next EXEC, or HALT on unsupported opcode.
  - EXEC:
    - Branch: assert pc_en; next FETCH (3 cycles).
    - Load or store: next MEM.
    - All others: next WB.
  - MEM:
    - Store: assert store_en and pc_en; next FETCH (4 cycles).
    - Load: next WB.
  - WB: assert load_en and pc_en; next FETCH. Loads take 5 cycles; ALU ops, jal, jalr and auipc take 4.
  - HALT: illegal = 1, all enables 0; stays in HALT until reset.
- Enable timing:
  - pc_en, load_en and store_en are each high for exactly one cycle per instruction.
  - These enables are never high in FETCH or DECODE.
- Decoded-field timing: op_ula, operation_type, ula_entry, sign, imm_ext and the mode flags are combinational from IR. They are stable from DECODE through the instruction's final state and change only after a FETCH.
- Supported opcodes; all others are illegal:
  - 0110011 R-type: ula_entry = 1, operation_type = 00.
  - 0010011 I-ALU: ula_entry = 0, operation_type = 00.
  - 0000011 load: op_ula = add, ula_entry = 0, operation_type = 01.
  - 0100011 store: op_ula = add, ula_entry = 0.
  - 1100011 branch: branch = 1, ula_entry = 1; op_ula from funct3.
  - 1101111 jal: jal = 1, operation_type = 10.
  - 1100111 jalr: jalr = 1, operation_type = 10.
  - 0010111 auipc: auipc = 1, operation_type = 10.
- op_ula encoding:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor.
  - 0101 slt; 0110 equ; 0111 ne; 1000 sge.
  - 1001 sll; 1010 srl; 1011 sra.
- ALU decode:
  - funct7[5] selects sub (R-type only) or sra.
  - For I-type shifts, shamt is IR[25:20]. Bit IR[30] selects srai.
- Branch mapping: beq to equ; bne to ne; blt/bltu to slt; bge/bgeu to sge.
- sign = 0 for sltu, sltiu, bltu and bgeu; otherwise 1.
- Immediates are sign-extended from the MSB of the field to BITS+1 bits:
  - I-type: IR[31:20].
  - S-type: {IR[31:25], IR[11:7]}.
  - B-type: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - J-type: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - U-type: {IR[31:12], 12'b0}.
- Writes to rd = x0 are still issued; the register bank handles x0.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined: adds output `retired_count` [BITS:0].
  - Reset value 0.
  - Increments by 1 on each clock where pc_en = 1.
  - Wraps from all-ones to 0.
  - Holds in HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- add x3,x1,x2 (32'h002081B3) after reset:
  - Required: FETCH, DECODE, EXEC, WB.
  - In WB: load_en = 1, pc_en = 1, op_ula = 0000, ula_entry = 1, operation_type = 00.
  - pc_en occurs exactly once in 4 cycles.
- ld x5,-8(x2) (32'hFF813283):
  - Required: imm_ext = 64'hFFFF_FFFF_FFFF_FFF8, operation_type = 01.
  - load_en and pc_en in cycle 5 only; store_en stays 0.
- sd x5,16(x2) (32'h00513823):
  - Required: store_en = 1 and pc_en = 1 in cycle 4 (MEM); load_en = 0 throughout; imm_ext = 16.
- bltu x1,x2,-4 (32'hFE20EEE3):
  - Required: branch = 1, op_ula = 0101, sign = 0, imm_ext = -4.
  - pc_en in cycle 3; no load_en or store_en.
- Opcode 7'b1111111:
  - Required: HALT entered after DECODE; illegal = 1; all enables 0 for 20+ cycles.
  - reset then returns to FETCH with illegal = 0.
- reset asserted during MEM of a load:
  - Required: next cycle state = FETCH; load_en and pc_en are never asserted for the aborted load.
  - retired_count (if enabled) is unchanged.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo
// Multi-cycle control unit for the RV64 datapath. Latches the instruction word
// into IR during FETCH, decodes it, and sequences FETCH/DECODE/EXEC/MEM/WB.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   instru          instruction word at the current PC
//   pc_en           one-cycle PC update strobe (last state of each instruction)
//   load_en         register-file write enable
//   store_en        data-RAM write enable
//   op_ula          ALU operation
//   operation_type  writeback source: 00 ula_out, 01 mem_read, 10 pc
//   ula_entry       ALU B source: 0 imm_ext, 1 rs2
//   branch/auipc/jal/jalr  PC-update mode flags
//   sign            signed compare when 1
//   imm_ext         sign-extended immediate
//   illegal         high while halted on an unsupported opcode
//   retired_count   retired-instruction counter (only with INSTR_COUNT_EN)
//
// Optional feature macro: INSTR_COUNT_EN.
module unidade_controle_multiciclo #(
  parameter int BITS = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instru,
  output logic          pc_en,
  output logic          load_en,
  output logic          store_en,
  output logic [3:0]    op_ula,
  output logic [1:0]    operation_type,
  output logic          ula_entry,
  output logic          branch,
  output logic          auipc,
  output logic          jal,
  output logic          jalr,
  output logic          sign,
  output logic [BITS:0] imm_ext,
  output logic          illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [BITS:0] retired_count
`endif
);

  localparam int unsigned W = BITS + 1;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_EQU = 4'b0110;
  localparam logic [3:0] ALU_NE  = 4'b0111;
  localparam logic [3:0] ALU_SGE = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc;
  logic       is_legal;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign alt    = ir_q[30];

  assign is_r      = (opcode == OPC_R);
  assign is_i      = (opcode == OPC_I);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_auipc;

  // State and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= IR_NOP;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and per-state enables; reset masks enables in the aborting cycle
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_en    = 1'b0;
    load_en  = 1'b0;
    store_en = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_d    = instru;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_store) begin
          store_en = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        load_en = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      pc_en    = 1'b0;
      load_en  = 1'b0;
      store_en = 1'b0;
      illegal  = 1'b0;
    end
  end

  // Field decode, combinational from IR so it holds from DECODE to the last state
  always_comb begin
    op_ula         = ALU_ADD;
    operation_type = 2'b00;
    ula_entry      = 1'b0;
    branch         = 1'b0;
    auipc          = 1'b0;
    jal            = 1'b0;
    jalr           = 1'b0;
    sign           = 1'b1;
    imm_ext        = '0;
    if (is_r || is_i) begin
      ula_entry = is_r;
      if (is_i) imm_ext = {{(W-12){ir_q[31]}}, ir_q[31:20]};
      unique case (funct3)
        3'b000: op_ula = (is_r && alt) ? ALU_SUB : ALU_ADD;
        3'b001: op_ula = ALU_SLL;
        3'b010: op_ula = ALU_SLT;
        3'b011: begin
          op_ula = ALU_SLT;
          sign   = 1'b0;
        end
        3'b100: op_ula = ALU_XOR;
        3'b101: op_ula = alt ? ALU_SRA : ALU_SRL;
        3'b110: op_ula = ALU_OR;
        default: op_ula = ALU_AND;
      endcase
    end else if (is_load) begin
      operation_type = 2'b01;
      imm_ext        = {{(W-12){ir_q[31]}}, ir_q[31:20]};
    end else if (is_store) begin
      imm_ext = {{(W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    end else if (is_branch) begin
      branch    = 1'b1;
      ula_entry = 1'b1;
      imm_ext   = {{(W-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      unique case (funct3)
        3'b001: op_ula = ALU_NE;
        3'b100: op_ula = ALU_SLT;
        3'b101: op_ula = ALU_SGE;
        3'b110: begin
          op_ula = ALU_SLT;
          sign   = 1'b0;
        end
        3'b111: begin
          op_ula = ALU_SGE;
          sign   = 1'b0;
        end
        default: op_ula = ALU_EQU;
      endcase
    end else if (is_jal) begin
      jal            = 1'b1;
      operation_type = 2'b10;
      imm_ext        = {{(W-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    end else if (is_jalr) begin
      jalr           = 1'b1;
      operation_type = 2'b10;
      imm_ext        = {{(W-12){ir_q[31]}}, ir_q[31:20]};
    end else if (is_auipc) begin
      auipc          = 1'b1;
      operation_type = 2'b10;
      imm_ext        = {{(W-32){ir_q[31]}}, ir_q[31:12], 12'b0};
    end
  end

`ifdef INSTR_COUNT_EN
  logic [BITS:0] retired_count_q, retired_count_d;

  // Retired-instruction counter, wraps naturally
  always_comb begin
    retired_count_d = retired_count_q;
    if (pc_en) retired_count_d = retired_count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) retired_count_q <= '0;
    else       retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for unidade_controle_multiciclo: directed instructions, expected
// responses queued at issue and checked by a monitor on every pc_en strobe.
module tb_unidade_controle_multiciclo;

  logic        clk;
  logic        reset;
  logic [31:0] instru;
  logic        pc_en, load_en, store_en;
  logic [3:0]  op_ula;
  logic [1:0]  operation_type;
  logic        ula_entry, branch, auipc, jal, jalr, sign, illegal;
  logic [63:0] imm_ext;
`ifdef INSTR_COUNT_EN
  logic [63:0] retired_count;
`endif

  unidade_controle_multiciclo #(.BITS(63)) dut (
    .clk            (clk),
    .reset          (reset),
    .instru         (instru),
    .pc_en          (pc_en),
    .load_en        (load_en),
    .store_en       (store_en),
    .op_ula         (op_ula),
    .operation_type (operation_type),
    .ula_entry      (ula_entry),
    .branch         (branch),
    .auipc          (auipc),
    .jal            (jal),
    .jalr           (jalr),
    .sign           (sign),
    .imm_ext        (imm_ext),
    .illegal        (illegal)
`ifdef INSTR_COUNT_EN
    ,
    .retired_count  (retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          lat;
    int          n_ld;
    int          n_st;
    logic [3:0]  op;
    logic [1:0]  ot;
    logic        ue, br, au, jl, jr, sg;
    logic [63:0] imm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(string name, int lat, int nld, int nst, logic [3:0] op,
                              logic [1:0] ot, logic ue, logic br, logic au, logic jl,
                              logic jr, logic sg, logic [63:0] imm);
    exp_t e;
    e.name = name; e.lat = lat; e.n_ld = nld; e.n_st = nst; e.op = op; e.ot = ot;
    e.ue = ue; e.br = br; e.au = au; e.jl = jl; e.jr = jr; e.sg = sg; e.imm = imm;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_fields(string tag, exp_t e);
    logic [79:0] got, want;
    got  = {op_ula, operation_type, ula_entry, branch, auipc, jal, jalr, sign, imm_ext};
    want = {e.op, e.ot, e.ue, e.br, e.au, e.jl, e.jr, e.sg, e.imm};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s fields: got op=%b ot=%b ue=%b br/au/jal/jalr=%b%b%b%b sign=%b imm=%h expected op=%b ot=%b ue=%b br/au/jal/jalr=%b%b%b%b sign=%b imm=%h",
               e.name, tag, op_ula, operation_type, ula_entry, branch, auipc, jal, jalr,
               sign, imm_ext, e.op, e.ot, e.ue, e.br, e.au, e.jl, e.jr, e.sg, e.imm);
    end
  endtask

  // Monitor: tracks cycles/enables per instruction and checks on each pc_en
  int cyc = 0, nld = 0, nst = 0;
  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; nld = 0; nst = 0;
    end else begin
      cyc++;
      if (load_en)  nld++;
      if (store_en) nst++;
      if (cyc == 2 && q.size() > 0) chk_fields("decode", q[0]);
      if (pc_en) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pc_en: got pc_en=1 at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_tests++;
          if (cyc != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
          end
          n_tests++;
          if (nld != e.n_ld || nst != e.n_st) begin
            n_fail++;
            $display("FAIL %s enables: got load_en x%0d store_en x%0d expected x%0d x%0d",
                     e.name, nld, nst, e.n_ld, e.n_st);
          end
          chk_fields("final", e);
        end
        cyc = 0; nld = 0; nst = 0;
      end
    end
  end

  task automatic run_instr(logic [31:0] ins, exp_t e);
    bit seen;
    instru = ins;
    q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (pc_en) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got no pc_en expected pc_en within 12 cycles", e.name);
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset  = 1'b1;
    instru = 32'h002081B3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_enables", 64'({pc_en, load_en, store_en, illegal, branch, auipc, jal, jalr}), 64'h0);
    chk("reset_decode", 64'({op_ula, operation_type, ula_entry, sign}), 64'h01);
    chk("reset_imm", imm_ext, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(32'h002081B3, mk("add",   4, 1, 0, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 1, 64'h0));
    run_instr(32'hFF813283, mk("ld",    5, 1, 0, 4'b0000, 2'b01, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8));
    run_instr(32'h00513823, mk("sd",    4, 0, 1, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1, 64'd16));
    run_instr(32'hFE20EEE3, mk("bltu",  3, 0, 0, 4'b0101, 2'b00, 1, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC));
    run_instr(32'h402081B3, mk("sub",   4, 1, 0, 4'b0001, 2'b00, 1, 0, 0, 0, 0, 1, 64'h0));
    run_instr(32'h40335293, mk("srai",  4, 1, 0, 4'b1011, 2'b00, 0, 0, 0, 0, 0, 1, 64'h403));
    run_instr(32'hFFF13093, mk("sltiu", 4, 1, 0, 4'b0101, 2'b00, 0, 0, 0, 0, 0, 0, ONES));
    run_instr(32'h008000EF, mk("jal",   4, 1, 0, 4'b0000, 2'b10, 0, 0, 0, 1, 0, 1, 64'd8));
    run_instr(32'h00008067, mk("jalr",  4, 1, 0, 4'b0000, 2'b10, 0, 0, 0, 0, 1, 1, 64'h0));
    run_instr(32'h12345297, mk("auipc", 4, 1, 0, 4'b0000, 2'b10, 0, 0, 1, 0, 0, 1, 64'h1234_5000));
    run_instr(32'h0020F463, mk("bgeu",  3, 0, 0, 4'b1000, 2'b00, 1, 1, 0, 0, 0, 0, 64'd8));

    // Unsupported opcode: HALT after DECODE, sticky until reset
    instru = 32'h0000007F;
    @(negedge clk);
    @(negedge clk);
    chk("illegal_decode", 64'({illegal, pc_en, load_en, store_en}), 64'h0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk("halt_hold", 64'({illegal, pc_en, load_en, store_en}), 64'h8);
    end
    do_reset(2);
    chk("halt_reset_illegal", 64'(illegal), 64'h0);
    run_instr(32'h002081B3, mk("add_after_halt", 4, 1, 0, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 1, 64'h0));

    // Reset during MEM of a load aborts it without any enable
    instru = 32'hFF813283;
    repeat (4) @(negedge clk);
    chk("abort_mem_enables", 64'({pc_en, load_en, store_en}), 64'h0);
    reset = 1'b1;
    #1 chk("abort_mem_reset_enables", 64'({pc_en, load_en, store_en}), 64'h0);
    @(posedge clk);
    #1 chk("abort_next_enables", 64'({pc_en, load_en, store_en}), 64'h0);
    @(negedge clk);
    chk("abort_next_mid_enables", 64'({pc_en, load_en, store_en}), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(32'h002081B3, mk("add_after_abort", 4, 1, 0, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 1, 64'h0));

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
